// File: rtl/dehaze_frame_sequencer.sv
// Frame sequencer for the dehazing datapath: two raster scans per frame (estimation, restoration),
// with latency-matched valid / line / frame flags on the restored-pixel stream.
module dehaze_frame_sequencer #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int ADDR_W   = 19,
  parameter int MEM_LAT  = 1,
  parameter int PIPE_LAT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              galc_rdy,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_en,
  output logic              pass,
  output logic              galc_rd,
  output logic              out_valid,
  output logic              sol,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int LAT   = MEM_LAT + PIPE_LAT;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [2:0] {IDLE, EST, WAIT_A, RESTORE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pass_q, pass_d;
  logic [LAT-1:0]    vld_q, vld_d;
  logic [LAT-1:0]    sol_q, sol_d;
  logic [LAT-1:0]    eol_q, eol_d;
  logic [LAT-1:0]    eof_q, eof_d;

  logic scan, issue, col_last, last_pix, feed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
      pass_q <= 1'b0;
      vld_q  <= '0;
      sol_q  <= '0;
      eol_q  <= '0;
      eof_q  <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
      pass_q <= pass_d;
      vld_q  <= vld_d;
      sol_q  <= sol_d;
      eol_q  <= eol_d;
      eof_q  <= eof_d;
    end
  end

  always_comb begin
    scan     = (state_q == EST) || (state_q == RESTORE);
    issue    = scan && !stall;
    col_last = (col_q == COL_W'(IMG_W - 1));
    last_pix = col_last && (row_q == ROW_W'(IMG_H - 1));
    feed     = issue && pass_q;
  end

  // Datapath: scan counters, pass flag and latency-matched flag shifters.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    pass_d = pass_q;
    if ((state_q == IDLE && start) || (state_q == WAIT_A && galc_rdy)) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (issue) begin
      if (last_pix) begin
        col_d  = '0;
        row_d  = '0;
        addr_d = '0;
      end else begin
        addr_d = addr_q + 1'b1;
        if (col_last) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
    if (state_q == WAIT_A && galc_rdy) pass_d = 1'b1;
    else if (state_q == DONE)          pass_d = 1'b0;
    // The flag shifters run every cycle regardless of stall so output timing tracks issue time.
    vld_d = (vld_q << 1) | LAT'(feed);
    sol_d = (sol_q << 1) | LAT'(feed && (col_q == '0));
    eol_d = (eol_q << 1) | LAT'(feed && col_last);
    eof_d = (eof_q << 1) | LAT'(feed && last_pix);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)              state_d = EST;
      EST:     if (issue && last_pix)  state_d = WAIT_A;
      WAIT_A:  if (galc_rdy)           state_d = RESTORE;
      RESTORE: if (issue && last_pix)  state_d = DRAIN;
      // Looking at the next shifter value lets DONE follow the final out_valid by one cycle.
      DRAIN:   if (vld_d == '0)        state_d = DONE;
      DONE:                            state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en     = issue;
    addr      = addr_q;
    pass      = pass_q;
    galc_rd   = (state_q == WAIT_A) && galc_rdy;
    out_valid = vld_q[LAT-1];
    sol       = sol_q[LAT-1];
    eol       = eol_q[LAT-1];
    eof       = eof_q[LAT-1];
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

endmodule

// File: tb/tb_dehaze_frame_sequencer.sv
// Directed bench for dehaze_frame_sequencer on a 4x2 image with MEM_LAT=1, PIPE_LAT=3.
module tb_dehaze_frame_sequencer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 3;
  localparam int NV = 25;

  logic          clk, rst, start, stall, galc_rdy;
  logic [AW-1:0] addr;
  logic          rd_en, pass, galc_rd, out_valid, sol, eol, eof, busy, done;

  dehaze_frame_sequencer #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .MEM_LAT(1), .PIPE_LAT(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .galc_rdy(galc_rdy),
    .addr(addr), .rd_en(rd_en), .pass(pass), .galc_rd(galc_rd),
    .out_valid(out_valid), .sol(sol), .eol(eol), .eof(eof), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic start, stall, galc_rdy;
    logic rd_en;
    int   addr;
    logic pass, galc_rd, ov, sol, eol, eof, busy, done;
  } vec_t;

  vec_t vt[NV];
  int   nchk  = 0;
  int   nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic sv(input int i, input bit st, input bit rd, input int a, input bit p,
                    input bit gr, input bit ov, input bit so, input bit eo, input bit ef,
                    input bit b, input bit d);
    vt[i].start = st; vt[i].stall = 1'b0; vt[i].galc_rdy = 1'b1;
    vt[i].rd_en = rd; vt[i].addr = a; vt[i].pass = p; vt[i].galc_rd = gr;
    vt[i].ov = ov; vt[i].sol = so; vt[i].eol = eo; vt[i].eof = ef;
    vt[i].busy = b; vt[i].done = d;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rd_en"}, rd_en, 0);
    chk({tag, " addr"}, addr, 0);
    chk({tag, " pass"}, pass, 0);
    chk({tag, " galc_rd"}, galc_rd, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " sol"}, sol, 0);
    chk({tag, " eol"}, eol, 0);
    chk({tag, " eof"}, eof, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
  endtask

  task automatic run_table(input string tag);
    string n;
    for (int i = 0; i < NV; i++) begin
      start = vt[i].start; stall = vt[i].stall; galc_rdy = vt[i].galc_rdy;
      #1;
      n = $sformatf("%s[%0d]", tag, i);
      chk({n, " rd_en"}, rd_en, vt[i].rd_en);
      if (vt[i].rd_en) chk({n, " addr"}, addr, vt[i].addr);
      chk({n, " pass"}, pass, vt[i].pass);
      chk({n, " galc_rd"}, galc_rd, vt[i].galc_rd);
      chk({n, " out_valid"}, out_valid, vt[i].ov);
      chk({n, " sol"}, sol, vt[i].sol);
      chk({n, " eol"}, eol, vt[i].eol);
      chk({n, " eof"}, eof, vt[i].eof);
      chk({n, " busy"}, busy, vt[i].busy);
      chk({n, " done"}, done, vt[i].done);
      cyc();
    end
    start = 1'b0;
  endtask

  initial begin
    logic [19:0] ov_m, eof_m, done_m, rd_m;
    int          gr_cnt, dn_cnt;
    bit          found;

    //  i  st rd a  p  gr ov so eo ef b  d
    sv(0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sv(1,  0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    sv(2,  0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    sv(3,  1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0);
    sv(4,  0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0);
    sv(5,  0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 0);
    sv(6,  0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0);
    sv(7,  0, 1, 6, 0, 0, 0, 0, 0, 0, 1, 0);
    sv(8,  0, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0);
    sv(9,  0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    sv(10, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    sv(11, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    sv(12, 1, 1, 2, 1, 0, 0, 0, 0, 0, 1, 0);
    sv(13, 0, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0);
    sv(14, 0, 1, 4, 1, 0, 1, 1, 0, 0, 1, 0);
    sv(15, 0, 1, 5, 1, 0, 1, 0, 0, 0, 1, 0);
    sv(16, 0, 1, 6, 1, 0, 1, 0, 0, 0, 1, 0);
    sv(17, 0, 1, 7, 1, 0, 1, 0, 1, 0, 1, 0);
    sv(18, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0);
    sv(19, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
    sv(20, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
    sv(21, 0, 0, 0, 1, 0, 1, 0, 1, 1, 1, 0);
    sv(22, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    sv(23, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sv(24, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; start = 1'b0; stall = 1'b0; galc_rdy = 1'b1;
    cyc();
    #1 chk_zero("reset");
    cyc();
    rst = 1'b0;

    run_table("frame");

    // Stall for 3 cycles after pass-2 address 2 was issued.
    start = 1'b1; cyc(); start = 1'b0;
    found = 0;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (pass && rd_en) begin found = 1; break; end
      cyc();
    end
    chk("stall wait pass2", found, 1);
    ov_m = '0; eof_m = '0; done_m = '0; rd_m = '0;
    for (int k = 0; k < 20; k++) begin
      stall = (k >= 3 && k <= 5);
      #1;
      if (k >= 3 && k <= 6) chk($sformatf("stall addr hold k=%0d", k), addr, 3);
      ov_m[k] = out_valid; eof_m[k] = eof; done_m[k] = done; rd_m[k] = rd_en;
      cyc();
    end
    stall = 1'b0;
    chk("stall rd_en pattern", rd_m, 20'h007C7);
    chk("stall out_valid pattern", ov_m, 20'h07C70);
    chk("stall out_valid count", $countones(ov_m), 8);
    chk("stall eof pattern", eof_m, 20'h04000);
    chk("stall done pattern", done_m, 20'h08000);

    // galc_rdy low for 20 cycles in WAIT_A; a galc_rdy pulse during EST is ignored.
    galc_rdy = 1'b0; gr_cnt = 0; dn_cnt = 0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int e = 0; e < 8; e++) begin
      galc_rdy = (e == 3);
      #1;
      chk($sformatf("galc est rd_en e=%0d", e), rd_en, 1);
      chk($sformatf("galc est galc_rd e=%0d", e), galc_rd, 0);
      chk($sformatf("galc est pass e=%0d", e), pass, 0);
      cyc();
    end
    galc_rdy = 1'b0;
    for (int w = 0; w < 20; w++) begin
      #1;
      chk($sformatf("wait_a rd_en w=%0d", w), rd_en, 0);
      chk($sformatf("wait_a galc_rd w=%0d", w), galc_rd, 0);
      chk($sformatf("wait_a busy w=%0d", w), busy, 1);
      chk($sformatf("wait_a pass w=%0d", w), pass, 0);
      cyc();
    end
    galc_rdy = 1'b1;
    #1 chk("galc_rd on rise", galc_rd, 1);
    if (galc_rd) gr_cnt++;
    cyc();
    #1;
    chk("restore pass", pass, 1);
    chk("restore rd_en", rd_en, 1);
    chk("restore addr0", addr, 0);
    found = 0;
    for (int t = 0; t < 40; t++) begin
      if (galc_rd) gr_cnt++;
      if (done) begin dn_cnt++; found = 1; end
      cyc(); #1;
      if (found) break;
    end
    chk("galc_rd pulse count", gr_cnt, 1);
    chk("galc seq done count", dn_cnt, 1);

    // Asynchronous reset in the middle of RESTORE.
    start = 1'b1; cyc(); start = 1'b0;
    found = 0;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (pass && rd_en && addr == 4) begin found = 1; break; end
      cyc();
    end
    chk("reset wait addr4", found, 1);
    #1 rst = 1'b1;
    #1 chk_zero("midreset");
    cyc();
    rst = 1'b0;
    dn_cnt = 0;
    for (int t = 0; t < 6; t++) begin
      #1;
      if (done) dn_cnt++;
      chk($sformatf("post reset busy t=%0d", t), busy, 0);
      chk($sformatf("post reset out_valid t=%0d", t), out_valid, 0);
      cyc();
    end
    chk("post reset done count", dn_cnt, 0);

    run_table("refrm");

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
